debug_mem_arb: RTL

- Shares the single-ported, 64-bit-wide debug ROM between NumReq requesters, e.g. hart instruction fetch and hart load port.
- Picks one requester per cycle using a round-robin pointer and drives that requester's address to the ROM.
- Routes the ROM data, one cycle later, back to the winning requester.
- Answers out-of-window addresses locally with an error response and does not touch the ROM.
- Sits between the hart-side debug memory ports and debug_rom inside the debug module.

---
 rtl/dbg_mem_pkg.sv | 36 +++
 rtl/rr_arb.sv | 76 +++++++
 rtl/debug_mem_arb.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dbg_mem_pkg.sv
// Shared types and helpers for the debug memory arbiter.
//   DbgRomBase / DbgRomWords : default debug ROM window (byte base, depth in 64-bit words)
//   dbg_mem_req_t            : one requester's read request {req, addr}
//   dbg_mem_rsp_t            : one requester's response {gnt, rvalid, rdata, err}
//   in_rom_window()          : full-width window decode, immune to base+size overflow
package dbg_mem_pkg;

    localparam logic [63:0]  DbgRomBase  = 64'h0000_0000_0000_0800;
    localparam int unsigned  DbgRomWords = 32'd20;

    typedef struct packed {
        logic        req;
        logic [63:0] addr;
    } dbg_mem_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [63:0] rdata;
        logic        err;
    } dbg_mem_rsp_t;

    // Window check done in 65 bits so base + words*8 can never wrap around.
    function automatic logic in_rom_window(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input logic [31:0] words);
        logic [64:0] a_ext;
        logic [64:0] lo_ext;
        logic [64:0] hi_ext;
        a_ext  = {1'b0, addr};
        lo_ext = {1'b0, base};
        hi_ext = lo_ext + {30'd0, words, 3'b000};
        return (a_ext >= lo_ext) && (a_ext < hi_ext);
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// searching cyclically, then moves the pointer just past the winner.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : per-requester request
//   gnt_o         : one-hot grant (combinational)
//   gnt_idx_o     : index of the granted requester
//   gnt_any_o     : a grant was issued this cycle
module rr_arb #(
    parameter int unsigned NumReq = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumReq-1:0]         req_i,
    output logic [NumReq-1:0]         gnt_o,
    output logic [$clog2(NumReq)-1:0] gnt_idx_o,
    output logic                      gnt_any_o
);

    localparam int unsigned IdxW = $clog2(NumReq);

    logic [IdxW-1:0]   ptr_r;
    logic [IdxW-1:0]   ptr_nxt_s;
    logic [NumReq-1:0] gnt_s;
    logic [IdxW-1:0]   idx_s;
    logic              any_s;

    // Cyclic priority search starting at the pointer.
    always_comb begin
        gnt_s = '0;
        idx_s = '0;
        any_s = 1'b0;
        for (int i = 0; i < int'(NumReq); i++) begin
            int              cand;
            logic [IdxW-1:0] cand_idx;
            cand = int'(ptr_r) + i;
            if (cand >= int'(NumReq)) begin
                cand = cand - int'(NumReq);
            end else begin
                cand = cand;
            end
            cand_idx = IdxW'(cand);
            if (!any_s && req_i[cand_idx]) begin
                any_s           = 1'b1;
                idx_s           = cand_idx;
                gnt_s[cand_idx] = 1'b1;
            end else begin
                any_s = any_s;
            end
        end
    end

    // Pointer wraps from NumReq-1 back to 0.
    always_comb begin
        if (idx_s == IdxW'(NumReq - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = idx_s + IdxW'(1);
        end
    end

    // Pointer register; holds when nothing is granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_r <= '0;
        end else if (any_s) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign gnt_o     = gnt_s;
    assign gnt_idx_o = idx_s;
    assign gnt_any_o = any_s;

endmodule

// File: rtl/debug_mem_arb.sv
// Debug ROM arbiter: shares the single-ported 64-bit debug ROM among NumReq
// requesters with a round-robin grant, answers out-of-window reads locally with
// an error, and routes the ROM data back to the winner one cycle later.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   req_i, addr_i     : per-requester read request and byte address
//   gnt_o             : one-hot grant, same cycle as the accepted request
//   rvalid_o, rdata_o, err_o : per-requester response, one cycle after grant
//   rom_req_o, rom_addr_o    : ROM read strobe and window-relative byte address
//   rom_rdata_i       : ROM data, valid the cycle after rom_req_o
//   stall_cnt_o       : per-requester stall counters
// Optional feature macro: DEBUG_MEM_ARB_STALL_CNT_EN enables the saturating
// stall counters; otherwise stall_cnt_o is tied to zero.
// AddrWidth is expected to be at most 64.
module debug_mem_arb
    import dbg_mem_pkg::*;
#(
    parameter int unsigned          NumReq    = 2,
    parameter int unsigned          AddrWidth = 64,
    parameter logic [AddrWidth-1:0] RomBase   = AddrWidth'(DbgRomBase),
    parameter int unsigned          RomWords  = DbgRomWords
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumReq-1:0]                req_i,
    input  logic [NumReq-1:0][AddrWidth-1:0] addr_i,
    output logic [NumReq-1:0]                gnt_o,
    output logic [NumReq-1:0]                rvalid_o,
    output logic [NumReq-1:0][63:0]          rdata_o,
    output logic [NumReq-1:0]                err_o,
    output logic                             rom_req_o,
    output logic [AddrWidth-1:0]             rom_addr_o,
    input  logic [63:0]                      rom_rdata_i,
    output logic [NumReq-1:0][31:0]          stall_cnt_o
);

    localparam int unsigned IdxW = $clog2(NumReq);

    logic [NumReq-1:0]    gnt_s;
    logic [IdxW-1:0]      gnt_idx_s;
    logic                 gnt_any_s;
    dbg_mem_req_t         sel_s;
    logic                 in_win_s;
    logic                 rom_req_s;
    logic [AddrWidth-1:0] rom_addr_s;
    logic [AddrWidth-1:0] rom_addr_r;
    logic                 resp_valid_r;
    logic [IdxW-1:0]      resp_owner_r;
    logic                 resp_err_r;
    dbg_mem_rsp_t         rsp_s [NumReq];

    rr_arb #(
        .NumReq (NumReq)
    ) u_rr_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .gnt_o     (gnt_s),
        .gnt_idx_o (gnt_idx_s),
        .gnt_any_o (gnt_any_s)
    );

    // Window decode of the winner; out-of-window grants leave the ROM idle
    // and rom_addr_o parked on its last driven value.
    always_comb begin
        sel_s.req  = gnt_any_s;
        sel_s.addr = 64'(addr_i[gnt_idx_s]);
        in_win_s   = in_rom_window(sel_s.addr, 64'(RomBase), 32'(RomWords));
        if (sel_s.req && in_win_s) begin
            rom_req_s  = 1'b1;
            rom_addr_s = addr_i[gnt_idx_s] - RomBase;
        end else begin
            rom_req_s  = 1'b0;
            rom_addr_s = rom_addr_r;
        end
    end

    // Response bookkeeping: who owns the t+1 response and whether it is an error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rom_addr_r   <= '0;
            resp_valid_r <= 1'b0;
            resp_owner_r <= '0;
            resp_err_r   <= 1'b0;
        end else begin
            rom_addr_r   <= rom_addr_s;
            resp_valid_r <= gnt_any_s;
            resp_owner_r <= gnt_any_s ? gnt_idx_s : resp_owner_r;
            resp_err_r   <= gnt_any_s && !in_win_s;
        end
    end

    // Route the response to its owner; all other lanes stay quiet.
    always_comb begin
        for (int k = 0; k < int'(NumReq); k++) begin
            logic own;
            own              = resp_valid_r && (resp_owner_r == IdxW'(k));
            rsp_s[k].gnt     = gnt_s[k];
            rsp_s[k].rvalid  = own;
            rsp_s[k].err     = own && resp_err_r;
            if (own && !resp_err_r) begin
                rsp_s[k].rdata = rom_rdata_i;
            end else begin
                rsp_s[k].rdata = 64'h0;
            end
        end
    end

    // Flatten per-lane responses onto the output ports.
    always_comb begin
        for (int k = 0; k < int'(NumReq); k++) begin
            gnt_o[k]    = rsp_s[k].gnt;
            rvalid_o[k] = rsp_s[k].rvalid;
            rdata_o[k]  = rsp_s[k].rdata;
            err_o[k]    = rsp_s[k].err;
        end
    end

    assign rom_req_o  = rom_req_s;
    assign rom_addr_o = rom_addr_s;

`ifdef DEBUG_MEM_ARB_STALL_CNT_EN
    logic [NumReq-1:0][31:0] stall_cnt_r;

    // Saturating count of cycles each requester waited without a grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_r <= '0;
        end else begin
            for (int k = 0; k < int'(NumReq); k++) begin
                if (req_i[k] && !gnt_s[k] && (stall_cnt_r[k] != 32'hFFFF_FFFF)) begin
                    stall_cnt_r[k] <= stall_cnt_r[k] + 32'd1;
                end else begin
                    stall_cnt_r[k] <= stall_cnt_r[k];
                end
            end
        end
    end

    assign stall_cnt_o = stall_cnt_r;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
